// File: rtl/mem_pkg.sv
// Shared encodings for the CPU-side data RAM initiator: access sizes (RAM data_length
// values), completion codes and controller states.
package mem_pkg;

   typedef enum logic [1:0] {
      BYTE       = 2'd0,
      HALFWORD   = 2'd1,
      WORD       = 2'd2,
      DOUBLEWORD = 2'd3
   } size_e;

   typedef enum logic [1:0] {
      ERR_OK       = 2'b00,
      ERR_MISALIGN = 2'b01,
      ERR_RISE_TO  = 2'b10,
      ERR_FALL_TO  = 2'b11
   } err_e;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      ASSERT,
      RELEASE,
      DONE
   } state_e;

   function automatic logic misaligned(input size_e size, input logic [2:0] low);
      case (size)
         HALFWORD:   misaligned = low[0];
         WORD:       misaligned = |low[1:0];
         DOUBLEWORD: misaligned = |low;
         default:    misaligned = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mem_load_format.sv
// Builds the 64-bit load result from the captured RAM beats: sign/zero extension for
// BYTE/HALFWORD/WORD, plain concatenation for DOUBLEWORD.
module mem_load_format
   import mem_pkg::*;
(
   input  size_e       size,
   input  logic        sign_ext,
   input  logic [31:0] beat0,
   input  logic [31:0] beat1,
   output logic [63:0] rdata
);

   always_comb begin
      rdata = '0;
      case (size)
         BYTE:     rdata = {{56{sign_ext & beat0[7]}},  beat0[7:0]};
         HALFWORD: rdata = {{48{sign_ext & beat0[15]}}, beat0[15:0]};
         WORD:     rdata = {{32{sign_ext & beat0[31]}}, beat0};
         default:  rdata = {beat0, beat1};
      endcase
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store initiator for the byte-addressed data RAM: four-phase enable/MFC handshake
// with per-edge timeout; doublewords are issued as two WORD beats at addr and addr+4.
module mem_access_ctrl
   import mem_pkg::*;
#(
   parameter int unsigned ADDR_W  = 9,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req,
   input  logic              req_rw,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [63:0]       req_wdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [1:0]        err_code,
   output logic [63:0]       rdata,
   output logic              mem_enable,
   output logic              mem_read_write,
   output logic [1:0]        mem_data_length,
   output logic [ADDR_W-1:0] mem_address,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_mfc
);

   localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   state_e            state;
   logic [TW-1:0]     timer;
   logic              beat;
   logic              rw_q;
   size_e             size_q;
   logic              sign_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_lo_q;
   logic [31:0]       beat0_q;
   logic [31:0]       beat1_q;
   logic [63:0]       load_value;
   size_e             req_size_e;
   logic              timer_expired;

   assign req_size_e    = size_e'(req_size);
   assign timer_expired = (timer == TW'(TIMEOUT - 1));

   // Doubleword stores send the upper word first, at the lower address.
   function automatic logic [31:0] first_beat_wdata(input size_e size, input logic [63:0] wdata);
      case (size)
         BYTE:     first_beat_wdata = {24'b0, wdata[7:0]};
         HALFWORD: first_beat_wdata = {16'b0, wdata[15:0]};
         WORD:     first_beat_wdata = wdata[31:0];
         default:  first_beat_wdata = wdata[63:32];
      endcase
   endfunction

   function automatic size_e ram_length(input size_e size);
      ram_length = (size == DOUBLEWORD) ? WORD : size;
   endfunction

   mem_load_format u_format (
      .size     (size_q),
      .sign_ext (sign_q),
      .beat0    (beat0_q),
      .beat1    (beat1_q),
      .rdata    (load_value)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state           <= IDLE;
         timer           <= '0;
         beat            <= 1'b0;
         rw_q            <= 1'b1;
         size_q          <= BYTE;
         sign_q          <= 1'b0;
         addr_q          <= '0;
         wdata_lo_q      <= '0;
         beat0_q         <= '0;
         beat1_q         <= '0;
         busy            <= 1'b0;
         done            <= 1'b0;
         err             <= 1'b0;
         err_code        <= ERR_OK;
         rdata           <= '0;
         mem_enable      <= 1'b0;
         mem_read_write  <= 1'b1;
         mem_data_length <= '0;
         mem_address     <= '0;
         mem_wdata       <= '0;
      end else begin
         case (state)
            IDLE: begin
               timer <= '0;
               if (req) begin
                  busy <= 1'b1;
                  if (misaligned(req_size_e, req_addr[2:0])) begin
                     state    <= DONE;
                     done     <= 1'b1;
                     err      <= 1'b1;
                     err_code <= ERR_MISALIGN;
                  end else begin
                     state           <= SETUP;
                     beat            <= 1'b0;
                     rw_q            <= req_rw;
                     size_q          <= req_size_e;
                     sign_q          <= req_signed;
                     addr_q          <= req_addr;
                     wdata_lo_q      <= req_wdata[31:0];
                     mem_read_write  <= req_rw;
                     mem_data_length <= ram_length(req_size_e);
                     mem_address     <= req_addr;
                     mem_wdata       <= first_beat_wdata(req_size_e, req_wdata);
                  end
               end
            end

            SETUP: begin
               mem_enable <= 1'b1;
               state      <= ASSERT;
               timer      <= '0;
            end

            ASSERT: begin
               if (mem_mfc) begin
                  if (!beat) beat0_q <= mem_rdata;
                  else       beat1_q <= mem_rdata;
                  mem_enable <= 1'b0;
                  state      <= RELEASE;
                  timer      <= '0;
               end else if (timer_expired) begin
                  mem_enable <= 1'b0;
                  state      <= DONE;
                  done       <= 1'b1;
                  err        <= 1'b1;
                  err_code   <= ERR_RISE_TO;
                  timer      <= '0;
               end else begin
                  timer <= timer + 1'b1;
               end
            end

            RELEASE: begin
               if (!mem_mfc) begin
                  timer <= '0;
                  if (size_q == DOUBLEWORD && !beat) begin
                     beat        <= 1'b1;
                     mem_address <= addr_q + ADDR_W'(4);
                     mem_wdata   <= wdata_lo_q;
                     state       <= SETUP;
                  end else begin
                     state <= DONE;
                     done  <= 1'b1;
                     if (rw_q) rdata <= load_value;
                  end
               end else if (timer_expired) begin
                  state    <= DONE;
                  done     <= 1'b1;
                  err      <= 1'b1;
                  err_code <= ERR_FALL_TO;
                  timer    <= '0;
               end else begin
                  timer <= timer + 1'b1;
               end
            end

            DONE: begin
               done     <= 1'b0;
               busy     <= 1'b0;
               err      <= 1'b0;
               err_code <= ERR_OK;
               state    <= IDLE;
               timer    <= '0;
            end

            default: begin
               state <= IDLE;
               timer <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: a big-endian byte RAM responder with selectable
// MFC behaviour, and a request-level reference model checked on every cycle.
module tb_mem_access_ctrl;

   localparam int TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        req;
   logic        req_rw;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [8:0]  req_addr;
   logic [63:0] req_wdata;
   logic        busy, done, err;
   logic [1:0]  err_code;
   logic [63:0] rdata;
   logic        mem_enable, mem_read_write;
   logic [1:0]  mem_data_length;
   logic [8:0]  mem_address;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_mfc;

   always #5 clk = ~clk;

   mem_access_ctrl #(.ADDR_W(9), .TIMEOUT(TIMEOUT)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .req             (req),
      .req_rw          (req_rw),
      .req_size        (req_size),
      .req_signed      (req_signed),
      .req_addr        (req_addr),
      .req_wdata       (req_wdata),
      .busy            (busy),
      .done            (done),
      .err             (err),
      .err_code        (err_code),
      .rdata           (rdata),
      .mem_enable      (mem_enable),
      .mem_read_write  (mem_read_write),
      .mem_data_length (mem_data_length),
      .mem_address     (mem_address),
      .mem_wdata       (mem_wdata),
      .mem_rdata       (mem_rdata),
      .mem_mfc         (mem_mfc)
   );

   // RAM responder: mode 0 = mfc follows enable, 1 = mfc stuck low, 2 = mfc stuck high.
   logic [7:0] ram [512];
   int         mode;
   int         pulses;
   logic [8:0] pulse_addr [$];
   logic [8:0] a1, a2, a3;

   assign mem_mfc = (mode == 0) ? mem_enable : (mode == 2);
   assign a1 = mem_address + 9'd1;
   assign a2 = mem_address + 9'd2;
   assign a3 = mem_address + 9'd3;

   always_comb begin
      mem_rdata = '0;
      case (mem_data_length)
         2'd0:    mem_rdata = {24'b0, ram[mem_address]};
         2'd1:    mem_rdata = {16'b0, ram[mem_address], ram[a1]};
         default: mem_rdata = {ram[mem_address], ram[a1], ram[a2], ram[a3]};
      endcase
   end

   always @(posedge mem_enable) begin
      pulses <= pulses + 1;
      pulse_addr.push_back(mem_address);
      if (!mem_read_write) begin
         case (mem_data_length)
            2'd0: ram[mem_address] <= mem_wdata[7:0];
            2'd1: begin
               ram[mem_address] <= mem_wdata[15:8];
               ram[a1]          <= mem_wdata[7:0];
            end
            default: begin
               ram[mem_address] <= mem_wdata[31:24];
               ram[a1]          <= mem_wdata[23:16];
               ram[a2]          <= mem_wdata[15:8];
               ram[a3]          <= mem_wdata[7:0];
            end
         endcase
      end
   end

   // Reference model state
   logic [7:0]  ref_mem [512];
   logic [63:0] model_rdata;
   logic [63:0] exp_rdata;
   logic        exp_load;
   logic        exp_err;
   logic [1:0]  exp_code;
   int          exp_start;
   int          exp_done;
   int          cyc;
   int          en_cycles;
   int          nvec;
   int          nfail;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
      nvec++;
      if (act !== expv) begin
         nfail++;
         $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, expv);
      end
   endtask

   // Advance to the next falling edge and check every output against the model.
   task automatic cycle();
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
         chk("rst_busy", busy, 0);
         chk("rst_done", done, 0);
         chk("rst_err", err, 0);
         chk("rst_rdata", rdata, 0);
         chk("rst_enable", mem_enable, 0);
         chk("rst_rw", mem_read_write, 1);
      end else begin
         if (mem_enable) en_cycles++;
         if (cyc == exp_done && exp_load) model_rdata = exp_rdata;
         chk("done", done, (cyc == exp_done));
         chk("busy", busy, (cyc >= exp_start && cyc <= exp_done));
         chk("rdata", rdata, model_rdata);
         if (cyc == exp_done) begin
            chk("err", err, exp_err);
            chk("err_code", err_code, exp_code);
         end
      end
   endtask

   task automatic set_expect(input logic rw, input logic [1:0] size, input logic sgn,
                             input logic [8:0] addr, input logic [63:0] wd, input int rsp,
                             output int lat);
      int          nb;
      int          code;
      logic [63:0] v;
      nb = 1 << size;
      if ((addr % nb) != 0)  begin lat = 1;           code = 1; end
      else if (rsp == 1)     begin lat = 2 + TIMEOUT; code = 2; end
      else if (rsp == 2)     begin lat = 3 + TIMEOUT; code = 3; end
      else                   begin lat = (nb == 8) ? 7 : 4; code = 0; end
      exp_start = cyc + 1;
      exp_done  = cyc + lat;
      exp_err   = (code != 0);
      exp_code  = 2'(code);
      exp_load  = rw && (code == 0);
      if (code == 0) begin
         if (rw) begin
            v = '0;
            for (int i = 0; i < nb; i++) v = (v << 8) | 64'(ref_mem[int'(addr) + i]);
            if (sgn && nb < 8 && v[8*nb-1]) v = v | (~64'd0 << (8*nb));
            exp_rdata = v;
         end else begin
            for (int i = 0; i < nb; i++) ref_mem[int'(addr) + i] = wd[8*(nb-1-i) +: 8];
         end
      end
   endtask

   task automatic drive(input logic rw, input logic [1:0] size, input logic sgn,
                        input logic [8:0] addr, input logic [63:0] wd, input int rsp);
      mode       = rsp;
      req        = 1'b1;
      req_rw     = rw;
      req_size   = size;
      req_signed = sgn;
      req_addr   = addr;
      req_wdata  = wd;
   endtask

   task automatic request(input logic rw, input logic [1:0] size, input logic sgn,
                          input logic [8:0] addr, input logic [63:0] wd, input int rsp);
      int lat;
      drive(rw, size, sgn, addr, wd, rsp);
      set_expect(rw, size, sgn, addr, wd, rsp, lat);
      cycle();
      req = 1'b0;
      repeat (lat + 1) cycle();
   endtask

   int p0, e0, lat_unused;

   initial begin
      reset_n = 1'b0; req = 1'b0; req_rw = 1'b1; req_size = '0; req_signed = 1'b0;
      req_addr = '0; req_wdata = '0; mode = 0;
      model_rdata = '0; exp_rdata = '0; exp_load = 1'b0; exp_err = 1'b0; exp_code = '0;
      exp_start = -1; exp_done = -1; cyc = 0; en_cycles = 0; nvec = 0; nfail = 0;
      repeat (3) cycle();
      reset_n = 1'b1;
      cycle();

      // WORD store then signed and unsigned loads
      request(0, 2'd2, 0, 9'd8, 64'h0000_0000_DEAD_BEEF, 0);
      chk("ram_bytes_8_11", {ram[8], ram[9], ram[10], ram[11]}, 64'hDEAD_BEEF);
      request(1, 2'd2, 1, 9'd8, '0, 0);
      chk("lit_word_signed", rdata, 64'hFFFF_FFFF_DEAD_BEEF);
      request(1, 2'd2, 0, 9'd8, '0, 0);
      chk("lit_word_unsigned", rdata, 64'h0000_0000_DEAD_BEEF);

      // BYTE extension
      request(0, 2'd0, 0, 9'd3, 64'h80, 0);
      request(1, 2'd0, 1, 9'd3, '0, 0);
      chk("lit_byte_signed", rdata, 64'hFFFF_FFFF_FFFF_FF80);
      request(1, 2'd0, 0, 9'd3, '0, 0);
      chk("lit_byte_unsigned", rdata, 64'h0000_0000_0000_0080);

      // HALFWORD
      request(0, 2'd1, 0, 9'd6, 64'hA5C3, 0);
      request(1, 2'd1, 1, 9'd6, '0, 0);
      chk("lit_half_signed", rdata, 64'hFFFF_FFFF_FFFF_A5C3);

      // DOUBLEWORD as two beats at 16 and 20
      p0 = pulses;
      request(0, 2'd3, 0, 9'd16, 64'h0123_4567_89AB_CDEF, 0);
      chk("dw_wr_pulses", 64'(pulses - p0), 2);
      chk("dw_wr_addr0", pulse_addr[p0], 16);
      chk("dw_wr_addr1", pulse_addr[p0 + 1], 20);
      p0 = pulses;
      request(1, 2'd3, 0, 9'd16, '0, 0);
      chk("lit_dw_read", rdata, 64'h0123_4567_89AB_CDEF);
      chk("dw_rd_pulses", 64'(pulses - p0), 2);
      chk("dw_rd_addr0", pulse_addr[p0], 16);
      chk("dw_rd_addr1", pulse_addr[p0 + 1], 20);

      // Highest aligned doubleword
      request(0, 2'd3, 0, 9'd504, 64'hFEDC_BA98_7654_3210, 0);
      request(1, 2'd3, 1, 9'd504, '0, 0);
      chk("lit_dw_504", rdata, 64'hFEDC_BA98_7654_3210);

      // Misaligned requests: no RAM access, rdata held
      p0 = pulses;
      request(1, 2'd1, 0, 9'd5, '0, 0);
      request(0, 2'd3, 0, 9'd20, 64'h1111_2222_3333_4444, 0);
      request(1, 2'd2, 0, 9'd10, '0, 0);
      chk("misalign_pulses", 64'(pulses - p0), 0);
      chk("lit_misalign_hold", rdata, 64'hFEDC_BA98_7654_3210);

      // MFC never rises, then MFC never falls
      e0 = en_cycles;
      request(1, 2'd2, 0, 9'd8, '0, 1);
      chk("rise_to_enable_cycles", 64'(en_cycles - e0), 64'(TIMEOUT));
      request(1, 2'd2, 0, 9'd8, '0, 2);
      chk("lit_timeout_hold", rdata, 64'hFEDC_BA98_7654_3210);

      // Reset while in ASSERT
      drive(1, 2'd2, 0, 9'd8, '0, 1);
      exp_start = cyc + 1; exp_done = cyc + 1000; exp_load = 1'b0;
      cycle();
      req = 1'b0;
      cycle();
      cycle();
      chk("assert_enable_high", mem_enable, 1);
      #2 reset_n = 1'b0;
      #1;
      chk("async_rst_enable", mem_enable, 0);
      chk("async_rst_busy", busy, 0);
      model_rdata = '0; exp_start = -1; exp_done = -1;
      cycle();
      cycle();
      reset_n = 1'b1;
      cycle();
      request(1, 2'd2, 1, 9'd8, '0, 0);
      chk("lit_after_reset", rdata, 64'hFFFF_FFFF_DEAD_BEEF);

      lat_unused = 0;
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
